rotation_profile_ctrl: RTL
==========================

Name: rotation_profile_ctrl

Overview:
Closed-loop rotation sequencer for one swerve wheel. Sits directly downstream of the delta calculator and consumes its delta_angle, dir_shortest and calc_updated outputs. Periodically requests a new delta via enable_calc and drives a ramped PWM duty and direction toward the PWM generator until the wheel is within tolerance. Reports done, or a timeout fault.

Parameters:
CALC_PERIOD, 16'd5000, clock cycles in HOLD between successive delta requests
TOLERANCE, 12'd8, delta_angle at or below this is on target
DECEL_ZONE, 12'd256, delta below this caps duty at MIN_PWM
MAX_PWM, 8'd255, cruise duty ceiling
MIN_PWM, 8'd32, minimum moving duty and the duty at which direction may flip
RAMP_STEP, 8'd4, duty change per evaluation
MAX_UPDATES, 16'd1000, evaluations allowed per move before timeout
CALC_WDOG, 8'd64, max cycles waiting for calc_updated

Ports:
reset_n  in  1  asynchronous active-low reset
clock  in  1  main clock
start_rotation  in  1  pulse; begins a move; ignored while busy
abort  in  1  level; forces stop
enable_calc  out  1  one-cycle request to the delta calculator
calc_updated  in  1  one-cycle pulse; delta_angle/dir_shortest valid
delta_angle  in  12  shortest distance to target
dir_shortest  in  1  1=CCW, 0=CW
pwm_duty  out  8  duty to the PWM generator
pwm_dir  out  1  applied direction
pwm_enable  out  1  motor drive enable
busy  out  1  high in any state except IDLE/DONE
done  out  1  one-cycle pulse on reaching target
timeout_err  out  1  sticky fault flag

Behaviour:
- Reset: reset_n asynchronous, active-low; clock is clock. All outputs are 0. FSM is in IDLE. Counters are cleared.
- States: IDLE, REQUEST, WAIT_CALC, EVALUATE, HOLD, DONE, FAULT.
- IDLE -> REQUEST on start_rotation. This clears timeout_err and the update counter.
- REQUEST: enable_calc=1 for exactly one cycle, then -> WAIT_CALC.
- WAIT_CALC: on calc_updated, register delta/dir and go to EVALUATE.
  - The watchdog counts cycles. If it reaches CALC_WDOG without calc_updated -> FAULT.
  - The upstream delay is 7 cycles from enable_calc to calc_updated.
- EVALUATE (1 cycle): increment the update counter.
  - If delta<=TOLERANCE -> DONE.
  - Else if counter==MAX_UPDATES -> FAULT.
  - Else compute duty, set pwm_enable=1, and go to HOLD.
- Duty rules:
  - cap = MIN_PWM if delta<DECEL_ZONE, else MAX_PWM.
  - If dir_shortest==pwm_dir, or pwm_duty<=MIN_PWM: set pwm_dir=dir_shortest and step the duty toward cap by RAMP_STEP, saturating at cap. Stepping from 0 goes to MIN_PWM first.
  - Otherwise (reversal at speed): keep pwm_dir and step the duty down by RAMP_STEP, floored at MIN_PWM.
  - All arithmetic is 9-bit with saturation. There is no wrap.
- HOLD: count CALC_PERIOD cycles, then -> REQUEST. Outputs are held.
- DONE: pwm_duty=0, pwm_enable=0, done=1 for one cycle, then -> IDLE.
- FAULT: pwm_duty=0, pwm_enable=0, timeout_err=1. Leave only on start_rotation (-> REQUEST) or abort (-> IDLE). timeout_err stays set until the next start.
- abort has priority in every state. The next cycle is IDLE with pwm_enable=0 and pwm_duty=0. No done pulse is issued. timeout_err is unchanged.
- start_rotation and abort asserted in the same cycle: abort wins.
- calc_updated outside WAIT_CALC is ignored.

Decomposition:
- rotation_pkg: FSM state localparams, the 1=CCW/0=CW direction encoding, default parameter values.
- Sub-module duty_ramp:
  - Combinational/registered saturating step of the current duty toward the cap.
  - Inputs: current duty, cap, step, reverse flag.
  - Output: next duty.

Test Plan:
- Start with the delta model returning 2000/CCW every request -> duty goes 32,36,40,… up to 255. pwm_dir=1. enable_calc fires every CALC_PERIOD+~9 cycles.
- Delta sequence 2000,1000,200,5 -> duty drops to 32 when delta=200. At 5, done pulses once, and pwm_enable and pwm_duty go 0.
- At duty 100 CW, the model returns dir=CCW (delta=1500) -> duty 96,92,…,32 with pwm_dir=0, then pwm_dir=1 and ramp up.
- Model never returns calc_updated -> FAULT 64 cycles after enable_calc. timeout_err=1, pwm off. start_rotation clears it.
- Model always returns delta=500 with MAX_UPDATES=10 -> FAULT on the 10th evaluation. done never asserts.
- abort in HOLD at duty 200 -> IDLE next cycle with duty 0, enable 0, no done. Assert reset_n low mid-move -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/rotation_profile_ctrl_pkg.sv
// Shared types and default tuning for the swerve wheel rotation sequencer.
package rotation_profile_ctrl_pkg;

  localparam int ANGLE_W = 12;
  localparam int DUTY_W  = 8;

  // Direction encoding used by both the delta calculator and the PWM stage
  localparam logic DIR_CCW = 1'b1;
  localparam logic DIR_CW  = 1'b0;

  // Default tuning values
  localparam logic [15:0]        DEF_CALC_PERIOD = 16'd5000;
  localparam logic [ANGLE_W-1:0] DEF_TOLERANCE   = 12'd8;
  localparam logic [ANGLE_W-1:0] DEF_DECEL_ZONE  = 12'd256;
  localparam logic [DUTY_W-1:0]  DEF_MAX_PWM     = 8'd255;
  localparam logic [DUTY_W-1:0]  DEF_MIN_PWM     = 8'd32;
  localparam logic [DUTY_W-1:0]  DEF_RAMP_STEP   = 8'd4;
  localparam logic [15:0]        DEF_MAX_UPDATES = 16'd1000;
  localparam logic [7:0]         DEF_CALC_WDOG   = 8'd64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_CALC,
    ST_EVALUATE,
    ST_HOLD,
    ST_DONE,
    ST_FAULT
  } state_t;

  // Close to the target the wheel creeps at the minimum duty, otherwise it may cruise
  function automatic logic [DUTY_W-1:0] select_cap(
    input logic [ANGLE_W-1:0] delta,
    input logic [ANGLE_W-1:0] decel_zone,
    input logic [DUTY_W-1:0]  min_pwm,
    input logic [DUTY_W-1:0]  max_pwm
  );
    return (delta < decel_zone) ? min_pwm : max_pwm;
  endfunction

endpackage

// File: rtl/rotation_profile_ctrl_if.sv
// Handshake between the rotation sequencer and the upstream delta calculator.
interface rotation_profile_ctrl_if;
  import rotation_profile_ctrl_pkg::*;

  logic               enable_calc;
  logic               calc_updated;
  logic [ANGLE_W-1:0] delta_angle;
  logic               dir_shortest;

  modport master (
    output enable_calc,
    input  calc_updated,
    input  delta_angle,
    input  dir_shortest
  );

  modport slave (
    input  enable_calc,
    output calc_updated,
    output delta_angle,
    output dir_shortest
  );

endinterface

// File: rtl/rotation_profile_ctrl_duty_ramp.sv
// One saturating duty step: toward the cap when driving, down to the
// minimum duty when braking for a direction reversal.
module duty_ramp
  import rotation_profile_ctrl_pkg::*;
#(
  parameter logic [DUTY_W-1:0] MIN_PWM = DEF_MIN_PWM
) (
  input  logic [DUTY_W-1:0] duty,
  input  logic [DUTY_W-1:0] cap,
  input  logic [DUTY_W-1:0] step,
  input  logic              reverse,
  output logic [DUTY_W-1:0] next_duty
);

  logic [DUTY_W:0] sum;
  logic [DUTY_W:0] up_base;
  logic [DUTY_W:0] brake_floor;

  // Nine-bit arithmetic so neither the step up nor the step down can wrap
  always_comb begin
    sum         = {1'b0, duty} + {1'b0, step};
    up_base     = (duty < MIN_PWM) ? {1'b0, MIN_PWM} : sum;
    brake_floor = {1'b0, MIN_PWM} + {1'b0, step};
    next_duty   = duty;
    if (reverse) begin
      if ({1'b0, duty} <= brake_floor) begin
        next_duty = MIN_PWM;
      end else begin
        next_duty = duty - step;
      end
    end else begin
      if (up_base > {1'b0, cap}) begin
        next_duty = cap;
      end else begin
        next_duty = up_base[DUTY_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rotation_profile_ctrl.sv
// Closed-loop rotation sequencer: periodically asks the delta calculator
// for the remaining angle and ramps the PWM duty/direction until on target.
module rotation_profile_ctrl
  import rotation_profile_ctrl_pkg::*;
#(
  parameter logic [15:0]        CALC_PERIOD = DEF_CALC_PERIOD,
  parameter logic [ANGLE_W-1:0] TOLERANCE   = DEF_TOLERANCE,
  parameter logic [ANGLE_W-1:0] DECEL_ZONE  = DEF_DECEL_ZONE,
  parameter logic [DUTY_W-1:0]  MAX_PWM     = DEF_MAX_PWM,
  parameter logic [DUTY_W-1:0]  MIN_PWM     = DEF_MIN_PWM,
  parameter logic [DUTY_W-1:0]  RAMP_STEP   = DEF_RAMP_STEP,
  parameter logic [15:0]        MAX_UPDATES = DEF_MAX_UPDATES,
  parameter logic [7:0]         CALC_WDOG   = DEF_CALC_WDOG
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_rotation,
  input  logic                  abort,
  rotation_profile_ctrl_if.master calc,
  output logic [DUTY_W-1:0]     pwm_duty,
  output logic                  pwm_dir,
  output logic                  pwm_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  state_t             state;
  logic               enable_calc_q;
  logic [15:0]        hold_cnt;
  logic [7:0]         wdog_cnt;
  logic [15:0]        update_cnt;
  logic [ANGLE_W-1:0] delta_q;
  logic               dir_q;
  logic [DUTY_W-1:0]  cap;
  logic               reverse;
  logic [DUTY_W-1:0]  ramp_next;
  logic [15:0]        update_next;

  assign calc.enable_calc = enable_calc_q;

  // Ramp inputs derived from the latest registered delta
  always_comb begin
    cap         = select_cap(delta_q, DECEL_ZONE, MIN_PWM, MAX_PWM);
    reverse     = (dir_q != pwm_dir) && (pwm_duty > MIN_PWM);
    update_next = update_cnt + 16'd1;
  end

  duty_ramp #(
    .MIN_PWM (MIN_PWM)
  ) u_duty_ramp (
    .duty      (pwm_duty),
    .cap       (cap),
    .step      (RAMP_STEP),
    .reverse   (reverse),
    .next_duty (ramp_next)
  );

  // Sequencer FSM; every output is registered alongside the state it belongs to
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      enable_calc_q <= 1'b0;
      hold_cnt      <= '0;
      wdog_cnt      <= '0;
      update_cnt    <= '0;
      delta_q       <= '0;
      dir_q         <= DIR_CW;
      pwm_duty      <= '0;
      pwm_dir       <= DIR_CW;
      pwm_enable    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      enable_calc_q <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        state      <= ST_IDLE;
        pwm_duty   <= '0;
        pwm_enable <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE, ST_FAULT: begin
            if (start_rotation) begin
              state         <= ST_REQUEST;
              enable_calc_q <= 1'b1;
              timeout_err   <= 1'b0;
              update_cnt    <= '0;
              busy          <= 1'b1;
            end
          end
          ST_REQUEST: begin
            state    <= ST_WAIT_CALC;
            wdog_cnt <= 8'd1;
          end
          ST_WAIT_CALC: begin
            if (calc.calc_updated) begin
              delta_q <= calc.delta_angle;
              dir_q   <= calc.dir_shortest;
              state   <= ST_EVALUATE;
            end else if (wdog_cnt + 8'd1 == CALC_WDOG) begin
              state       <= ST_FAULT;
              pwm_duty    <= '0;
              pwm_enable  <= 1'b0;
              timeout_err <= 1'b1;
            end else begin
              wdog_cnt <= wdog_cnt + 8'd1;
            end
          end
          ST_EVALUATE: begin
            update_cnt <= update_next;
            if (delta_q <= TOLERANCE) begin
              state      <= ST_DONE;
              pwm_duty   <= '0;
              pwm_enable <= 1'b0;
              done       <= 1'b1;
              busy       <= 1'b0;
            end else if (update_next == MAX_UPDATES) begin
              state       <= ST_FAULT;
              pwm_duty    <= '0;
              pwm_enable  <= 1'b0;
              timeout_err <= 1'b1;
            end else begin
              state      <= ST_HOLD;
              pwm_duty   <= ramp_next;
              pwm_dir    <= reverse ? pwm_dir : dir_q;
              pwm_enable <= 1'b1;
              hold_cnt   <= '0;
            end
          end
          ST_HOLD: begin
            if (hold_cnt == CALC_PERIOD - 16'd1) begin
              state         <= ST_REQUEST;
              enable_calc_q <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
